input_fm_reader: RTL and testbench
==================================

# input_fm_reader

Read-side sequencer for the 4-bank input feature-map buffer. It walks one buffered tile in channel-group/row/column order. Each cycle it drives four bank read addresses, one channel per bank, and captures the read data after the fixed 1-cycle bank latency. It then streams 4-word beats to the compute array over a valid/ready handshake. It sits between `input_fm` (read ports 0-3) and the convolution PE array.

## Interface
- `AW`, 16, bank address width
- `DW`, 32, data width
- `Tm`, 16, tile channels; multiple of 4
- `Tr`, 64, tile rows
- `Tc`, 16, tile columns; `Tr*Tc` is a power of two, 4..4096
- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous and active-low
- `start` in 1: one-cycle pulse; begin a tile read; ignored unless IDLE
- `busy` out 1: high from the cycle after an accepted start until `done`
- `done` out 1: one-cycle pulse after the final beat handshake
- `rd_addr0..3` out AW: read addresses to banks 0-3
- `rd_data0..3` in DW: bank read data, valid 1 cycle after the address
- `out_data` out 4*DW: beat; `[DW-1:0]` from bank0, up to `[4DW-1:3DW]` from bank3
- `out_valid` out 1: beat available
- `out_ready` in 1: consumer accepts the beat
- `out_last` out 1: qualifies the final beat of the tile

## Operation
- Storage layout: channel `ch` lives in bank `ch%4`, at address `ch*Tr*Tc + r*Tc + c`, truncated to AW bits.
- Loop order: outermost group `g` in `0..Tm/4-1`, then row `r` in `0..Tr-1`, then column `c` in `0..Tc-1`.
  - Per beat, `rd_addrI = (4g+I)*Tr*Tc + r*Tc + c`.
  - Total beats per tile = `Tm/4*Tr*Tc`.
- Address generation is incremental: column counter, row offset (`+Tc`) and group base (`+4*Tr*Tc`). No multipliers.
- State machine:
  - IDLE: on `start`, go to RUN and clear the counters.
  - RUN: issue a read when `fifo_cnt + inflight < 3`. After the last address is issued, go to DRAIN.
  - DRAIN: wait until the FIFO is empty and nothing is in flight, then go to DONE.
  - DONE: pulse `done` for one cycle, then return to IDLE.
- Issue tracking:
  - The `inflight` flag is set in the cycle an address is issued.
  - In the following cycle, the four `rd_data` words are written into a 3-entry output FIFO.
  - Addresses hold their value when not issuing; unissued reads are discarded.
- The output FIFO head drives `out_data`, `out_valid` and `out_last`. A pop occurs on `out_valid && out_ready`.
- `start` while not in IDLE is ignored, with no effect on counters.
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_last`=0, `rd_addr*`=0, `out_data`=0, FIFO empty, state IDLE.
- Asserting `rst_n` low mid-tile aborts immediately. No `done` is produced and FIFO contents are dropped.

## Timing
- `start` sampled high in cycle 0:
  - `rd_addr*` of beat 0 driven in cycle 1
  - `rd_data*` captured at the end of cycle 2
  - `out_valid` high in cycle 3
- With `out_ready` held high, throughput is 1 beat/cycle with no bubbles. Last beat in cycle `2+N`, `done` in cycle `3+N`, where N is the beat count.
- With `out_ready` low: at most 3 beats are buffered, after which issue stops. Issue resumes the cycle after the first pop, with no beat lost or duplicated.
- `out_data`, `out_valid` and `out_last` are stable while `out_valid && !out_ready`.
- `busy` falls in the same cycle `done` pulses. A new `start` is accepted from the next cycle.

## Configuration
- `INPUT_FM_READER_STALL_CNT_EN`
  - Defined: adds output `stall_cnt` [31:0], cleared on accepted `start`. It increments every cycle `out_valid && !out_ready`, saturates at `32'hFFFF_FFFF`, and holds after `done`. Reset value 0.
  - Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Basic sweep, `Tm=8,Tr=2,Tc=2`, `out_ready`=1, one start:
  - Beats 0/1/4 carry addresses (0,4,8,12)/(1,5,9,13)/(16,20,24,28).
  - 8 beats total; `out_last` only on beat 7.
  - `done` pulses exactly once, in cycle 11.
- Bank model returns `data = {bank, addr}` and `out_ready` toggles every cycle: data matches the address sequence, and no beat is dropped or duplicated.
- `out_ready`=0 for 10 cycles after the first `out_valid`: exactly 3 beats are issued and the addresses freeze. On release, beats resume at beat 0 in order.
- `start` re-pulsed mid-tile is ignored: address sequence unchanged, a single `done`.
- `rst_n` low at beat 3 of default params: all outputs go to reset values within the same cycle. A fresh `start` then produces 4096 beats from address 0.
- With `INPUT_FM_READER_STALL_CNT_EN`: 5 stall cycles on the basic sweep give `stall_cnt`=5 after `done`.

Source files
------------

// File: rtl/input_fm_reader.sv
// input_fm_reader: walks a 4-bank input feature-map tile and streams 4-word beats over valid/ready.
// Optional stall counter output enabled by defining INPUT_FM_READER_STALL_CNT_EN.
module input_fm_reader #(
    parameter int AW = 16,
    parameter int DW = 32,
    parameter int Tm = 16,
    parameter int Tr = 64,
    parameter int Tc = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [AW-1:0]   rd_addr0,
    output logic [AW-1:0]   rd_addr1,
    output logic [AW-1:0]   rd_addr2,
    output logic [AW-1:0]   rd_addr3,
    input  logic [DW-1:0]   rd_data0,
    input  logic [DW-1:0]   rd_data1,
    input  logic [DW-1:0]   rd_data2,
    input  logic [DW-1:0]   rd_data3,
    output logic [4*DW-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last
`ifdef INPUT_FM_READER_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);
    localparam int P  = Tr * Tc;
    localparam int N  = Tm / 4 * P;
    localparam int PW = $clog2(P);
    localparam int BW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic [AW-1:0]   addr_q [4];
    logic [AW-1:0]   addr_d [4];
    logic [AW-1:0]   nxt_q, nxt_d, cur;
    logic [PW-1:0]   pos_q, pos_d, cur_pos;
    logic [BW-1:0]   beat_q, beat_d, cur_beat;
    logic            iss_q, iss_d, iss_last_q, iss_last_d;
    logic            ret_q, ret_d, ret_last_q, ret_last_d;
    logic [4*DW:0]   mem_q [3];
    logic [4*DW:0]   mem_d [3];
    logic [4*DW:0]   head;
    logic [1:0]      wp_q, wp_d, rp_q, rp_d, cnt_q, cnt_d;
    logic            first, issue, last_beat, pop;
    logic [2:0]      occ;

    assign head      = mem_q[rp_q];
    assign out_valid = cnt_q != 2'd0;
    assign out_data  = head[4*DW-1:0];
    assign out_last  = out_valid & head[4*DW];
    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_addr0  = addr_q[0];
    assign rd_addr1  = addr_q[1];
    assign rd_addr2  = addr_q[2];
    assign rd_addr3  = addr_q[3];

    always_comb begin
        pop       = out_valid && out_ready;
        // occupancy after this cycle's pop: buffered beats plus reads on the bus and returning
        occ       = 3'(cnt_q) + 3'(iss_q) + 3'(ret_q) - 3'(pop);
        first     = state_q == S_IDLE && start;
        issue     = first || (state_q == S_RUN && occ < 3'd3);
        cur       = first ? '0 : nxt_q;
        cur_pos   = first ? '0 : pos_q;
        cur_beat  = first ? '0 : beat_q;
        last_beat = cur_beat == BW'(N - 1);
        state_d   = first ? S_RUN
                  : (state_q == S_RUN && issue && last_beat) ? S_DRAIN
                  : (state_q == S_DRAIN && occ == 3'd0) ? S_DONE
                  : (state_q == S_DONE) ? S_IDLE
                  : state_q;
        done_d    = state_q == S_DRAIN && occ == 3'd0;
        busy_d    = first || (busy_q && !done_d);
        for (int i = 0; i < 4; i++)
            addr_d[i] = issue ? cur + AW'(i * P) : addr_q[i];
        // crossing into the next channel group skips the three other channels held in each bank
        nxt_d      = !issue ? nxt_q : (cur_pos == PW'(P - 1)) ? cur + AW'(3 * P + 1) : cur + AW'(1);
        pos_d      = issue ? cur_pos + PW'(1) : pos_q;
        beat_d     = issue ? cur_beat + BW'(1) : beat_q;
        iss_d      = issue;
        iss_last_d = issue && last_beat;
        ret_d      = iss_q;
        ret_last_d = iss_last_q;
        for (int i = 0; i < 3; i++)
            mem_d[i] = (ret_q && wp_q == 2'(i)) ? {ret_last_q, rd_data3, rd_data2, rd_data1, rd_data0} : mem_q[i];
        wp_d  = !ret_q ? wp_q : (wp_q == 2'd2) ? 2'd0 : wp_q + 2'd1;
        rp_d  = !pop ? rp_q : (rp_q == 2'd2) ? 2'd0 : rp_q + 2'd1;
        cnt_d = cnt_q + 2'(ret_q) - 2'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '{default: '0};
            nxt_q      <= '0;
            pos_q      <= '0;
            beat_q     <= '0;
            iss_q      <= 1'b0;
            iss_last_q <= 1'b0;
            ret_q      <= 1'b0;
            ret_last_q <= 1'b0;
            mem_q      <= '{default: '0};
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            nxt_q      <= nxt_d;
            pos_q      <= pos_d;
            beat_q     <= beat_d;
            iss_q      <= iss_d;
            iss_last_q <= iss_last_d;
            ret_q      <= ret_d;
            ret_last_q <= ret_last_d;
            mem_q      <= mem_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef INPUT_FM_READER_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    assign stall_cnt = stall_q;

    always_comb begin
        stall_d = first ? '0
                : (out_valid && !out_ready && stall_q != '1) ? stall_q + 32'd1
                : stall_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_q <= '0;
        else
            stall_q <= stall_d;
    end
`endif
endmodule

// File: tb/tb_input_fm_reader.sv
// tb_input_fm_reader: scoreboard bench for input_fm_reader on an 8x2x2 tile with a 1-cycle bank model.
module tb_input_fm_reader;
    localparam int AW = 16, DW = 32, TM = 8, TR = 2, TC = 2;
    localparam int P = TR * TC, N = TM / 4 * P;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic busy, done, out_valid, out_last;
    logic [AW-1:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
    logic [DW-1:0] rd_data0, rd_data1, rd_data2, rd_data3;
    logic [4*DW-1:0] out_data;
`ifdef INPUT_FM_READER_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int errors = 0, checks = 0, cyc = 0, done_cnt = 0, done_cyc = 0, beats = 0;
    logic [4*DW:0] sb[$];
    logic [4*DW:0] exp_m;

    input_fm_reader #(.AW(AW), .DW(DW), .Tm(TM), .Tr(TR), .Tc(TC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
        .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data3(rd_data3),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
`ifdef INPUT_FM_READER_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // bank model: one-cycle latency, data = {bank, addr}
    always @(posedge clk) begin
        rd_data0 <= {16'd0, rd_addr0};
        rd_data1 <= {16'd1, rd_addr1};
        rd_data2 <= {16'd2, rd_addr2};
        rd_data3 <= {16'd3, rd_addr3};
    end

    always @(negedge clk) if (rst_n) begin
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (out_valid && out_ready) begin
            beats++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL beat_extra: got %h with nothing expected", {out_last, out_data});
            end else begin
                exp_m = sb.pop_front();
                if ({out_last, out_data} !== exp_m) begin
                    errors++;
                    $display("FAIL beat_data: got %h expected %h", {out_last, out_data}, exp_m);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [4*DW:0] exp_beat(int b);
        logic [4*DW:0] v;
        int a;
        v[4*DW] = (b == N - 1);
        for (int i = 0; i < 4; i++) begin
            a = (4 * (b / P) + i) * P + b % P;
            v[i*DW +: DW] = {16'(i), 16'(a)};
        end
        return v;
    endfunction

    task automatic push_tile();
        for (int b = 0; b < N; b++) sb.push_back(exp_beat(b));
        beats = 0;
        done_cnt = 0;
    endtask

    task automatic start_tile(output int t0);
        @(posedge clk); #1 start = 1'b1; t0 = cyc;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic check_tile_end(input string name);
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL %s_done_count: got %0d expected 1", name, done_cnt); end
        checks++;
        if (beats !== N || sb.size() !== 0) begin
            errors++; $display("FAIL %s_beats: got %0d beats, %0d left, expected %0d and 0", name, beats, sb.size(), N);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end: got %b expected 0", name, busy); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, out_valid, out_last} !== 4'b0) begin
            errors++; $display("FAIL rst_flags: got %b expected 0000", {busy, done, out_valid, out_last});
        end
        checks++;
        if ({rd_addr3, rd_addr2, rd_addr1, rd_addr0} !== 64'd0) begin
            errors++; $display("FAIL rst_addr: got %h expected 0", {rd_addr3, rd_addr2, rd_addr1, rd_addr0});
        end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL rst_data: got %h expected 0", out_data); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, out_valid} !== 2'b00) begin errors++; $display("FAIL idle_after_rst: got %b expected 00", {busy, out_valid}); end
    endtask

    task automatic test_basic();
        int t0, rel, fv = -1, lc = -1;
        out_ready = 1'b1;
        push_tile();
        start_tile(t0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            rel = cyc - t0;
            if (rel == 1) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
                checks++;
                if ({rd_addr3, rd_addr2, rd_addr1, rd_addr0} !== {16'd12, 16'd8, 16'd4, 16'd0}) begin
                    errors++; $display("FAIL basic_addr0: got %h expected 000c000800040000", {rd_addr3, rd_addr2, rd_addr1, rd_addr0});
                end
            end
            if (out_valid && fv < 0) fv = rel;
            if (out_valid && out_last) lc = rel;
        end
        checks++;
        if (fv !== 3) begin errors++; $display("FAIL basic_first_valid: got cycle %0d expected 3", fv); end
        checks++;
        if (lc !== 2 + N) begin errors++; $display("FAIL basic_last_cycle: got cycle %0d expected %0d", lc, 2 + N); end
        checks++;
        if (done_cyc - t0 !== 3 + N) begin errors++; $display("FAIL basic_done_cycle: got %0d expected %0d", done_cyc - t0, 3 + N); end
        check_tile_end("basic");
    endtask

    task automatic test_toggle();
        int t0;
        out_ready = 1'b0;
        push_tile();
        start_tile(t0);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1 out_ready = ~out_ready;
        end
        check_tile_end("toggle");
    endtask

    task automatic test_stall();
        int t0;
        logic stable;
        logic [4*DW:0] hd;
        out_ready = 1'b0;
        push_tile();
        hd = sb[0];
        start_tile(t0);
        for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || cyc - t0 !== 3) begin
            errors++; $display("FAIL stall_first_valid: got valid=%b at cycle %0d expected 1 at 3", out_valid, cyc - t0);
        end
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            if ({out_valid, out_last, out_data} !== {1'b1, hd}) stable = 1'b0;
        end
        checks++;
        if (!stable) begin errors++; $display("FAIL stall_hold: got %h expected held %h", {out_last, out_data}, hd); end
        checks++;
        if ({rd_addr3, rd_addr2, rd_addr1, rd_addr0} !== {16'd14, 16'd10, 16'd6, 16'd2}) begin
            errors++; $display("FAIL stall_addr_freeze: got %h expected 000e000a00060002", {rd_addr3, rd_addr2, rd_addr1, rd_addr0});
        end
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (30) @(negedge clk);
        check_tile_end("stall");
`ifdef INPUT_FM_READER_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 32'd10) begin errors++; $display("FAIL stall_cnt: got %0d expected 10", stall_cnt); end
`endif
    endtask

    task automatic test_restart();
        int t0;
        out_ready = 1'b1;
        push_tile();
        start_tile(t0);
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (25) @(negedge clk);
        check_tile_end("restart");
    endtask

    task automatic test_abort();
        int t0, k;
        out_ready = 1'b1;
        push_tile();
        start_tile(t0);
        k = 0;
        while (beats < 3 && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        checks++;
        if (beats !== 3) begin errors++; $display("FAIL abort_reach: got %0d beats expected 3", beats); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, out_valid, out_last} !== 4'b0 || out_data !== '0) begin
            errors++; $display("FAIL abort_outputs: got flags %b data %h expected 0", {busy, done, out_valid, out_last}, out_data);
        end
        checks++;
        if ({rd_addr3, rd_addr2, rd_addr1, rd_addr0} !== 64'd0) begin
            errors++; $display("FAIL abort_addr: got %h expected 0", {rd_addr3, rd_addr2, rd_addr1, rd_addr0});
        end
        checks++;
        if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt); end
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        push_tile();
        start_tile(t0);
        repeat (25) @(negedge clk);
        check_tile_end("abort_fresh");
    endtask

    initial begin
        test_reset();
        test_basic();
        repeat (3) @(posedge clk);
        test_toggle();
        repeat (3) @(posedge clk);
        test_stall();
        repeat (3) @(posedge clk);
        test_restart();
        repeat (3) @(posedge clk);
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
